// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store: one outstanding transaction and a response timeout.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_err,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  ls_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_req_valid,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wrt_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_data_valid
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t                state_reg, state_next;
    logic                  owner_reg, owner_next;      // 0 = IF, 1 = LS
    logic                  last_ls_reg, last_ls_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  we_reg, we_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic                  mem_req_valid_reg, mem_req_valid_next;
    logic                  mem_we_reg, mem_we_next;
    logic [1:0]            gnt_reg, gnt_next;
    logic                  resp_fire, resp_err;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  data_valid;

    // A floating or unknown data_valid must never complete a transaction.
    assign data_valid = (mem_data_valid === 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            owner_reg         <= 1'b0;
            last_ls_reg       <= 1'b1;
            cnt_reg           <= '0;
            addr_reg          <= '0;
            we_reg            <= 1'b0;
            wdata_reg         <= '0;
            mem_req_valid_reg <= 1'b0;
            mem_we_reg        <= 1'b0;
            gnt_reg           <= '0;
        end else begin
            state_reg         <= state_next;
            owner_reg         <= owner_next;
            last_ls_reg       <= last_ls_next;
            cnt_reg           <= cnt_next;
            addr_reg          <= addr_next;
            we_reg            <= we_next;
            wdata_reg         <= wdata_next;
            mem_req_valid_reg <= mem_req_valid_next;
            mem_we_reg        <= mem_we_next;
            gnt_reg           <= gnt_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        owner_next         = owner_reg;
        last_ls_next       = last_ls_reg;
        cnt_next           = cnt_reg;
        addr_next          = addr_reg;
        we_next            = we_reg;
        wdata_next         = wdata_reg;
        mem_req_valid_next = 1'b0;
        mem_we_next        = 1'b0;
        gnt_next           = '0;
        resp_fire          = 1'b0;
        resp_err           = 1'b0;
        resp_data          = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    // LS wins when alone, or when both ask and IF was served last.
                    owner_next         = ls_req && !(if_req && last_ls_reg);
                    addr_next          = owner_next ? ls_addr : if_addr;
                    we_next            = owner_next && ls_we;
                    wdata_next         = owner_next ? ls_wdata : '0;
                    mem_req_valid_next = 1'b1;
                    mem_we_next        = we_next;
                    gnt_next[owner_next] = 1'b1;
                    state_next         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                last_ls_next = owner_reg;
                cnt_next     = '0;
                state_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_valid) begin
                    resp_fire  = 1'b1;
                    resp_data  = we_reg ? '0 : mem_rd_data;
                    state_next = ST_IDLE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    resp_fire  = 1'b1;
                    resp_err   = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Per-port response registers; rdata/err hold until that port's next response.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic                  resp_hit;
            logic                  rvalid_reg;
            logic                  err_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            assign resp_hit = resp_fire && (owner_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    rvalid_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= resp_hit;
                    if (resp_hit) begin
                        err_reg   <= resp_err;
                        rdata_reg <= resp_data;
                    end
                end
            end
        end
    endgenerate

    assign if_gnt        = gnt_reg[0];
    assign ls_gnt        = gnt_reg[1];
    assign if_rvalid     = gen_port[0].rvalid_reg;
    assign if_rdata      = gen_port[0].rdata_reg;
    assign if_err        = gen_port[0].err_reg;
    assign ls_rvalid     = gen_port[1].rvalid_reg;
    assign ls_rdata      = gen_port[1].rdata_reg;
    assign ls_err        = gen_port[1].err_reg;
    assign mem_addr      = addr_reg;
    assign mem_req_valid = mem_req_valid_reg;
    assign mem_we        = mem_we_reg;
    assign mem_wrt_data  = wdata_reg;
endmodule
